// File: rtl/matmul3x3_stream_if.sv
// Valid/ready stream interface for matmul3x3_stream: a 3x3 matrix pair comes in
// and a 3x3 result with an overflow flag goes out. Element packing is row-major.
interface matmul3x3_stream_if #(
  parameter int DW = 9,
  parameter int OW = 2*DW+1
);
  logic            ivalid;
  logic            oready;
  logic [9*DW-1:0] iA;
  logic [9*DW-1:0] iB;
  logic            ovalid;
  logic            iready;
  logic [9*OW-1:0] oC;
  logic            oovf;

  // Master drives operands and the downstream ready; slave is the multiplier.
  modport master (output ivalid, iA, iB, iready, input oready, ovalid, oC, oovf);
  modport slave  (input ivalid, iA, iB, iready, output oready, ovalid, oC, oovf);
endinterface

// File: rtl/matmul3x3_stream.sv
// Two-stage pipelined 3x3 by 3x3 integer matrix multiplier, C = A*B.
// Stage 1 registers the 27 partial products, stage 2 sums each triple at
// full width (2*DW+2 bits) and reduces to OW bits by clamping or wrapping.
// OW must not exceed 2*DW+2. Flow control is valid/ready with bubble collapse.
module matmul3x3_stream #(
  parameter int DW     = 9,
  parameter int OW     = 2*DW+1,
  parameter bit SIGNED = 1'b1,
  parameter bit SAT    = 1'b1
) (
  input  logic               iclk,
  input  logic               irst_n,
  matmul3x3_stream_if.slave  bus
);

  localparam int PW = 2*DW;
  localparam int FW = 2*DW+2;

  // One partial product a*b, computed at 2*DW bits in the configured signedness.
  function automatic logic [PW-1:0] mul_elem(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [PW-1:0] ax;
    logic [PW-1:0] bx;
    if (SIGNED) begin
      ax = PW'($signed(a));
      bx = PW'($signed(b));
    end else begin
      ax = PW'(a);
      bx = PW'(b);
    end
    return ax * bx;
  endfunction

  // Widen a product to the full summation width.
  function automatic logic [FW-1:0] ext_prod(input logic [PW-1:0] p);
    logic [FW-1:0] r;
    if (SIGNED) begin
      r = FW'($signed(p));
    end else begin
      r = FW'(p);
    end
    return r;
  endfunction

  // Reduce a full-width sum to OW bits; MSB of the result is the overflow flag.
  function automatic logic [OW:0] reduce_sum(input logic [FW-1:0] s);
    logic [OW-1:0] lo;
    logic [FW-1:0] back;
    logic          ovf;
    logic [OW-1:0] res;
    lo = s[OW-1:0];
    if (SIGNED) begin
      back = FW'($signed(lo));
    end else begin
      back = FW'(lo);
    end
    ovf = (back != s);
    if (SAT && ovf) begin
      if (SIGNED) begin
        if (s[FW-1]) begin
          res = {1'b1, {(OW-1){1'b0}}};
        end else begin
          res = {1'b0, {(OW-1){1'b1}}};
        end
      end else begin
        // Unsigned sums are never negative, so overflow always means too large.
        res = {OW{1'b1}};
      end
    end else begin
      res = lo;
    end
    return {ovf, res};
  endfunction

  logic [PW-1:0]   prod_s [27];
  logic [PW-1:0]   prod_r [27];
  logic [FW-1:0]   sum_s;
  logic [OW:0]     red_s;
  logic [9*OW-1:0] c_s;
  logic            ovf_s;
  logic            s1_valid_r;
  logic            ovalid_r;
  logic            oovf_r;
  logic [9*OW-1:0] oc_r;
  logic            en1_s;
  logic            en2_s;

  // Stage 2 may load when empty or when its result is leaving this cycle;
  // stage 1 may load when empty or when it can pass its pair on.
  assign en2_s      = ~ovalid_r | bus.iready;
  assign en1_s      = ~s1_valid_r | en2_s;
  assign bus.oready = en1_s;
  assign bus.ovalid = ovalid_r;
  assign bus.oC     = oc_r;
  assign bus.oovf   = oovf_r;

  // Form the 27 partial products a(r,k)*b(k,c) of the incoming pair.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        for (int k = 0; k < 3; k++) begin
          prod_s[(3*r+c)*3+k] = mul_elem(bus.iA[(3*r+k)*DW +: DW], bus.iB[(3*k+c)*DW +: DW]);
        end
      end
    end
  end

  // Sum each product triple at full width, reduce to OW bits and gather overflow.
  always_comb begin
    c_s   = '0;
    ovf_s = 1'b0;
    sum_s = '0;
    red_s = '0;
    for (int e = 0; e < 9; e++) begin
      sum_s = ext_prod(prod_r[3*e]) + ext_prod(prod_r[3*e+1]) + ext_prod(prod_r[3*e+2]);
      red_s = reduce_sum(sum_s);
      c_s[e*OW +: OW] = red_s[OW-1:0];
      ovf_s = ovf_s | red_s[OW];
    end
  end

  // Stage 1: track occupancy and capture products only on an input transfer.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      s1_valid_r <= 1'b0;
      for (int i = 0; i < 27; i++) begin
        prod_r[i] <= '0;
      end
    end else begin
      if (en1_s) begin
        s1_valid_r <= bus.ivalid;
      end
      if (en1_s && bus.ivalid) begin
        for (int i = 0; i < 27; i++) begin
          prod_r[i] <= prod_s[i];
        end
      end
    end
  end

  // Stage 2: output registers, held during a downstream stall.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      ovalid_r <= 1'b0;
      oc_r     <= '0;
      oovf_r   <= 1'b0;
    end else begin
      if (en2_s) begin
        ovalid_r <= s1_valid_r;
      end
      if (en2_s && s1_valid_r) begin
        oc_r   <= c_s;
        oovf_r <= ovf_s;
      end
    end
  end

endmodule

// File: tb/tb_matmul3x3_stream.sv
// Directed bench for matmul3x3_stream: identity, signed/unsigned extremes under
// clamp and wrap, back-to-back streaming with a downstream stall, and reset
// asserted with pairs in flight.
module tb_matmul3x3_stream;

  logic iclk   = 1'b0;
  logic irst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 iclk = ~iclk;

  matmul3x3_stream_if #(.DW(9), .OW(19)) if0 ();
  matmul3x3_stream_if #(.DW(9), .OW(16)) if1 ();
  matmul3x3_stream_if #(.DW(9), .OW(16)) if2 ();
  matmul3x3_stream_if #(.DW(8), .OW(18)) if3 ();

  matmul3x3_stream #(.DW(9), .OW(19), .SIGNED(1'b1), .SAT(1'b1))
    u0 (.iclk(iclk), .irst_n(irst_n), .bus(if0.slave));
  matmul3x3_stream #(.DW(9), .OW(16), .SIGNED(1'b1), .SAT(1'b1))
    u1 (.iclk(iclk), .irst_n(irst_n), .bus(if1.slave));
  matmul3x3_stream #(.DW(9), .OW(16), .SIGNED(1'b1), .SAT(1'b0))
    u2 (.iclk(iclk), .irst_n(irst_n), .bus(if2.slave));
  matmul3x3_stream #(.DW(8), .OW(18), .SIGNED(1'b0), .SAT(1'b1))
    u3 (.iclk(iclk), .irst_n(irst_n), .bus(if3.slave));

  task automatic check_val(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint c0(input int i);
    return longint'($signed(if0.oC[i*19 +: 19]));
  endfunction
  function automatic longint c1(input int i);
    return longint'($signed(if1.oC[i*16 +: 16]));
  endfunction
  function automatic longint c2(input int i);
    return longint'($signed(if2.oC[i*16 +: 16]));
  endfunction
  function automatic longint c3(input int i);
    return longint'(if3.oC[i*18 +: 18]);
  endfunction

  // n on the diagonal, zero elsewhere (DW = 9).
  function automatic logic [80:0] diag9(input int n);
    logic [80:0] m;
    m = '0;
    for (int i = 0; i < 9; i++) begin
      if (i % 4 == 0) m[i*9 +: 9] = 9'(n);
    end
    return m;
  endfunction

  // Elements 1..9 in row-major order (DW = 9).
  function automatic logic [80:0] seq9();
    logic [80:0] m;
    m = '0;
    for (int i = 0; i < 9; i++) m[i*9 +: 9] = 9'(i + 1);
    return m;
  endfunction

  // Stream monitor: pair n (A = n*I, B = 1..9) must give C = n*(1..9), in order.
  int  n_out = 0;
  bit  mon_en = 1'b0;
  int  cyc = 0;
  int  out_cyc [10];

  always @(posedge iclk) cyc <= cyc + 1;

  always @(negedge iclk) begin
    if (mon_en && if0.ovalid && if0.iready) begin
      if (n_out < 10) begin
        check_val("stream_c00", c0(0), longint'(n_out + 1));
        check_val("stream_c22", c0(8), longint'(9 * (n_out + 1)));
        out_cyc[n_out] = cyc;
      end
      n_out++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    int nacc;
    int n;

    if0.ivalid = 1'b0; if0.iready = 1'b1; if0.iA = '0; if0.iB = '0;
    if1.ivalid = 1'b0; if1.iready = 1'b1; if1.iA = '0; if1.iB = '0;
    if2.ivalid = 1'b0; if2.iready = 1'b1; if2.iA = '0; if2.iB = '0;
    if3.ivalid = 1'b0; if3.iready = 1'b1; if3.iA = '0; if3.iB = '0;

    // Reset state
    repeat (2) @(negedge iclk);
    check_val("rst_ovalid", longint'(if0.ovalid), 0);
    check_val("rst_oc", longint'(|if0.oC), 0);
    check_val("rst_oovf", longint'(if0.oovf), 0);
    check_val("rst_oready", longint'(if0.oready), 1);
    @(posedge iclk); #1 irst_n = 1'b1;

    // Identity times 1..9
    @(posedge iclk); #1;
    if0.iA = diag9(1); if0.iB = seq9(); if0.ivalid = 1'b1;
    @(posedge iclk); #1;
    if0.ivalid = 1'b0; if0.iA = '0; if0.iB = '0;
    @(negedge iclk);
    check_val("id_lat1_ovalid", longint'(if0.ovalid), 0);
    @(negedge iclk);
    check_val("id_lat2_ovalid", longint'(if0.ovalid), 1);
    for (int i = 0; i < 9; i++) check_val("id_elem", c0(i), longint'(i + 1));
    check_val("id_oovf", longint'(if0.oovf), 0);
    pulses = 1;
    repeat (4) begin
      @(negedge iclk);
      if (if0.ovalid) pulses++;
    end
    check_val("id_pulses", longint'(pulses), 1);

    // Extremes: signed -256 on u0/u1/u2, unsigned 255 on u3
    @(posedge iclk); #1;
    if0.iA = {9{9'h100}}; if0.iB = {9{9'h100}}; if0.ivalid = 1'b1;
    if1.iA = {9{9'h100}}; if1.iB = {9{9'h100}}; if1.ivalid = 1'b1;
    if2.iA = {9{9'h100}}; if2.iB = {9{9'h100}}; if2.ivalid = 1'b1;
    if3.iA = {9{8'hFF}};  if3.iB = {9{8'hFF}};  if3.ivalid = 1'b1;
    @(posedge iclk); #1;
    if0.ivalid = 1'b0; if1.ivalid = 1'b0; if2.ivalid = 1'b0; if3.ivalid = 1'b0;
    @(negedge iclk);
    @(negedge iclk);
    check_val("ext_ovalid", longint'(if0.ovalid & if1.ovalid & if2.ovalid & if3.ovalid), 1);
    for (int i = 0; i < 9; i++) begin
      check_val("ext_full19", c0(i), 196608);
      check_val("ext_sat16", c1(i), 32767);
      check_val("ext_wrap16", c2(i), 0);
      check_val("ext_unsigned", c3(i), 195075);
    end
    check_val("ext_full19_ovf", longint'(if0.oovf), 0);
    check_val("ext_sat16_ovf", longint'(if1.oovf), 1);
    check_val("ext_wrap16_ovf", longint'(if2.oovf), 1);
    check_val("ext_unsigned_ovf", longint'(if3.oovf), 0);
    repeat (2) @(negedge iclk);

    // Back-to-back stream of 8 pairs with iready held high
    n_out = 0;
    mon_en = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge iclk); #1;
      if0.iA = diag9(k); if0.iB = seq9(); if0.ivalid = 1'b1;
    end
    @(posedge iclk); #1;
    if0.ivalid = 1'b0;
    for (int t = 0; t < 20 && n_out < 8; t++) @(negedge iclk);
    check_val("stream_count8", longint'(n_out), 8);
    check_val("stream_consecutive", longint'(out_cyc[7] - out_cyc[0]), 7);

    // Downstream stall: two more pairs fit, an eleventh is refused
    @(posedge iclk); #1;
    if0.iready = 1'b0;
    nacc = 0;
    n = 9;
    if0.iA = diag9(n); if0.iB = seq9(); if0.ivalid = 1'b1;
    repeat (5) begin
      @(negedge iclk);
      if (if0.ivalid && if0.oready) begin
        nacc++;
        n++;
      end
      @(posedge iclk); #1;
      if0.iA = diag9(n);
    end
    @(negedge iclk);
    check_val("stall_accepted", longint'(nacc), 2);
    check_val("stall_oready", longint'(if0.oready), 0);
    check_val("stall_ovalid", longint'(if0.ovalid), 1);
    check_val("stall_hold_c00", c0(0), 9);
    @(posedge iclk); #1;
    if0.ivalid = 1'b0;
    if0.iready = 1'b1;
    for (int t = 0; t < 20 && n_out < 10; t++) @(negedge iclk);
    check_val("stream_count10", longint'(n_out), 10);
    repeat (4) @(negedge iclk);
    check_val("stream_no_extra", longint'(n_out), 10);
    mon_en = 1'b0;

    // Reset with two pairs in flight
    @(posedge iclk); #1;
    if0.iA = diag9(2); if0.iB = seq9(); if0.ivalid = 1'b1;
    @(posedge iclk); #1;
    if0.iA = diag9(3);
    @(posedge iclk); #1;
    if0.ivalid = 1'b0;
    @(negedge iclk);
    check_val("inflight_ovalid", longint'(if0.ovalid), 1);
    #2 irst_n = 1'b0;
    #1;
    check_val("midrst_ovalid", longint'(if0.ovalid), 0);
    check_val("midrst_oc", longint'(|if0.oC), 0);
    check_val("midrst_oovf", longint'(if0.oovf), 0);
    @(posedge iclk); #1 irst_n = 1'b1;
    repeat (3) begin
      @(negedge iclk);
      check_val("postrst_idle_ovalid", longint'(if0.ovalid), 0);
    end
    @(posedge iclk); #1;
    if0.iA = diag9(4); if0.iB = seq9(); if0.ivalid = 1'b1;
    @(posedge iclk); #1;
    if0.ivalid = 1'b0;
    @(negedge iclk);
    check_val("postrst_lat1_ovalid", longint'(if0.ovalid), 0);
    @(negedge iclk);
    check_val("postrst_lat2_ovalid", longint'(if0.ovalid), 1);
    check_val("postrst_c00", c0(0), 4);
    check_val("postrst_c22", c0(8), 36);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
